// File: rtl/ysyx_22050550_trap_ctrl_pkg.sv
// Shared definitions for the M-mode trap sequencer: state encodings, CSR
// write-enable bit indices, mstatus field positions and trap cause values.
package ysyx_22050550_trap_ctrl_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } state_t;

    typedef enum logic {
        UPD_TRAP = 1'b0,
        UPD_RET  = 1'b1
    } upd_mode_t;

    localparam int CSR_MEPC    = 0;
    localparam int CSR_MCAUSE  = 1;
    localparam int CSR_MTVEC   = 2;
    localparam int CSR_MSTATUS = 3;
    localparam int CSR_MIE     = 4;
    localparam int CSR_MIP     = 5;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MTIE_BIT = 7;
    localparam int MTIP_BIT = 7;

    localparam logic [XLEN-1:0] MCAUSE_ECALL = 64'd11;
    localparam logic [XLEN-1:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_22050550_trap_ctrl_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (stack MIE into MPIE) and
// mret (restore MIE from MPIE). MPP is always forced to M-mode.
module ysyx_22050550_mstatus_upd
    import ysyx_22050550_trap_ctrl_pkg::*;
(
    input  upd_mode_t       mode,
    input  logic [XLEN-1:0] mstatus_in,
    output logic [XLEN-1:0] mstatus_out
);

    always_comb begin
        mstatus_out = mstatus_in;
        mstatus_out[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (mode == UPD_TRAP) begin
            mstatus_out[MSTATUS_MPIE] = mstatus_in[MSTATUS_MIE];
            mstatus_out[MSTATUS_MIE]  = 1'b0;
        end else begin
            mstatus_out[MSTATUS_MIE]  = mstatus_in[MSTATUS_MPIE];
            mstatus_out[MSTATUS_MPIE] = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_22050550_trap_ctrl.sv
// Trap sequencer: takes ecall/mret (and the machine timer interrupt when
// YSYX_22050550_TIMER_IRQ_EN is defined), writes the trap CSRs, then redirects fetch.
module ysyx_22050550_trap_ctrl
    import ysyx_22050550_trap_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    output logic            commit_ready,
    input  logic            commit_ecall,
    input  logic            commit_mret,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_npc,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    input  logic            timer_irq,
    output logic [XLEN-1:0] wbmepc,
    output logic [XLEN-1:0] wbmcause,
    output logic [XLEN-1:0] wbmstatus,
    output logic [XLEN-1:0] wbmip,
    output logic [7:0]      wbcsren,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            irq_pending;
    logic            mtip_mirror;
    upd_mode_t       upd_mode;
    logic [XLEN-1:0] mstatus_new;
    logic            unused_bits;

`ifdef YSYX_22050550_TIMER_IRQ_EN
    assign irq_pending = mstatus[MSTATUS_MIE] & mie[MTIE_BIT] & mip[MTIP_BIT];
    assign mtip_mirror = (timer_irq != mip[MTIP_BIT])
                         && (state_q != ST_TRAP) && (state_q != ST_RET);
    assign unused_bits = ^{mtvec[1:0], mie};
`else
    assign irq_pending = 1'b0;
    assign mtip_mirror = 1'b0;
    assign unused_bits = ^{mtvec[1:0], mie, mip, timer_irq};
`endif

    assign upd_mode = (state_q == ST_RET) ? UPD_RET : UPD_TRAP;

    ysyx_22050550_mstatus_upd u_mstatus_upd (
        .mode        (upd_mode),
        .mstatus_in  (mstatus),
        .mstatus_out (mstatus_new)
    );

    assign commit_ready = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    // An interrupt suppresses a committing ecall/mret, so epc points back at it.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (commit_valid) begin
                    if (irq_pending) begin
                        cause_d  = MCAUSE_MTI;
                        epc_d    = (commit_ecall || commit_mret) ? commit_pc : commit_npc;
                        target_d = {mtvec[XLEN-1:2], 2'b00};
                        state_d  = ST_TRAP;
                    end else if (commit_ecall) begin
                        cause_d  = MCAUSE_ECALL;
                        epc_d    = commit_pc;
                        target_d = {mtvec[XLEN-1:2], 2'b00};
                        state_d  = ST_TRAP;
                    end else if (commit_mret) begin
                        target_d = mepc;
                        state_d  = ST_RET;
                    end
                end
            end
            ST_TRAP:  state_d = ST_REDIR;
            ST_RET:   state_d = ST_REDIR;
            ST_REDIR: if (redirect_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // All write-back and redirect outputs are suppressed in the reset cycle.
    always_comb begin
        wbmepc         = '0;
        wbmcause       = '0;
        wbmstatus      = '0;
        wbmip          = '0;
        wbcsren        = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if (!reset) begin
            case (state_q)
                ST_TRAP: begin
                    wbcsren[CSR_MEPC]    = 1'b1;
                    wbcsren[CSR_MCAUSE]  = 1'b1;
                    wbcsren[CSR_MSTATUS] = 1'b1;
                    wbmepc               = epc_q;
                    wbmcause             = cause_q;
                    wbmstatus            = mstatus_new;
                end
                ST_RET: begin
                    wbcsren[CSR_MSTATUS] = 1'b1;
                    wbmstatus            = mstatus_new;
                end
                ST_REDIR: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                end
                default: ;
            endcase
            if (mtip_mirror) begin
                wbcsren[CSR_MIP] = 1'b1;
                wbmip            = {mip[XLEN-1:MTIP_BIT+1], timer_irq, mip[MTIP_BIT-1:0]};
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050550_trap_ctrl.sv
// Directed self-checking bench for the trap sequencer; timer expectations
// follow YSYX_22050550_TIMER_IRQ_EN.
module tb_ysyx_22050550_trap_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        commit_valid, commit_ready, commit_ecall, commit_mret;
    logic [63:0] commit_pc, commit_npc;
    logic [63:0] mepc, mtvec, mstatus, mie, mip;
    logic        timer_irq;
    logic [63:0] wbmepc, wbmcause, wbmstatus, wbmip;
    logic [7:0]  wbcsren;
    logic        redirect_valid, redirect_ready;
    logic [63:0] redirect_pc;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    ysyx_22050550_trap_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_ecall   (commit_ecall),
        .commit_mret    (commit_mret),
        .commit_pc      (commit_pc),
        .commit_npc     (commit_npc),
        .mepc           (mepc),
        .mtvec          (mtvec),
        .mstatus        (mstatus),
        .mie            (mie),
        .mip            (mip),
        .timer_irq      (timer_irq),
        .wbmepc         (wbmepc),
        .wbmcause       (wbmcause),
        .wbmstatus      (wbmstatus),
        .wbmip          (wbmip),
        .wbcsren        (wbcsren),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic ec, input logic mr,
                                 input logic [63:0] pc, input logic [63:0] npc);
        commit_valid = v;
        commit_ecall = ec;
        commit_mret  = mr;
        commit_pc    = pc;
        commit_npc   = npc;
        #1;
    endtask

    // Waits (bounded) for redirect_valid, checks the target, and completes the handshake.
    task automatic drainRedirect(input string tag, input logic [63:0] exp_pc);
        int n = 0;
        while (!redirect_valid && n < 8) begin
            tick();
            n++;
        end
        checkOutput({tag, "_rv"}, {63'd0, redirect_valid}, 64'd1);
        checkOutput({tag, "_rpc"}, redirect_pc, exp_pc);
        redirect_ready = 1'b1;
        tick();
        #1;
        checkOutput({tag, "_idle"}, {63'd0, commit_ready}, 64'd1);
    endtask

    initial begin
        reset          = 1'b1;
        redirect_ready = 1'b1;
        mepc           = '0;
        mtvec          = 64'h8000_0100;
        mstatus        = 64'hA_0000_1808;
        mie            = '0;
        mip            = '0;
        timer_irq      = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_commit_ready", {63'd0, commit_ready}, 64'd1);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_rv", {63'd0, redirect_valid}, 64'd0);
        checkOutput("rst_rpc", redirect_pc, 64'd0);
        checkOutput("rst_csren", {56'd0, wbcsren}, 64'd0);
        checkOutput("rst_wbmstatus", wbmstatus, 64'd0);

        // ecall
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0010, 64'h8000_0014);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("ecall_csren", {56'd0, wbcsren}, 64'h0B);
        checkOutput("ecall_mepc", wbmepc, 64'h8000_0010);
        checkOutput("ecall_mcause", wbmcause, 64'd11);
        checkOutput("ecall_mstatus", wbmstatus, 64'hA_0000_1880);
        checkOutput("ecall_ready_low", {63'd0, commit_ready}, 64'd0);
        checkOutput("ecall_busy", {63'd0, busy}, 64'd1);
        tick();
        checkOutput("ecall_redir_csren", {56'd0, wbcsren}, 64'd0);
        drainRedirect("ecall", 64'h8000_0100);

        // mret
        mstatus = 64'hA_0000_1880;
        mepc    = 64'h8000_0014;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h8000_0030, 64'h8000_0034);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("mret_csren", {56'd0, wbcsren}, 64'h08);
        checkOutput("mret_mstatus", wbmstatus, 64'hA_0000_1888);
        checkOutput("mret_ready_low1", {63'd0, commit_ready}, 64'd0);
        tick();
        checkOutput("mret_ready_low2", {63'd0, commit_ready}, 64'd0);
        drainRedirect("mret", 64'h8000_0014);

        // mret with MPIE=0 clears MIE
        mstatus = 64'h0000_0008;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h8000_0040, 64'h8000_0044);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("mret_mpie0_mstatus", wbmstatus, 64'h0000_1880);
        tick();
        drainRedirect("mret_mpie0", 64'h8000_0014);

        // plain commit stays idle
        mstatus = 64'hA_0000_1808;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0050, 64'h8000_0054);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("plain_busy", {63'd0, busy}, 64'd0);

        // redirect held off for 4 cycles
        redirect_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0060, 64'h8000_0064);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_rv", {63'd0, redirect_valid}, 64'd1);
            checkOutput("hold_rpc", redirect_pc, 64'h8000_0100);
            checkOutput("hold_ready", {63'd0, commit_ready}, 64'd0);
            tick();
        end
        drainRedirect("hold", 64'h8000_0100);

        // reset asserted during TRAP
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0070, 64'h8000_0074);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_csren_in_reset", {56'd0, wbcsren}, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rstmid_ready", {63'd0, commit_ready}, 64'd1);
        checkOutput("rstmid_rv", {63'd0, redirect_valid}, 64'd0);
        checkOutput("rstmid_csren", {56'd0, wbcsren}, 64'd0);
        checkOutput("rstmid_busy", {63'd0, busy}, 64'd0);

        // timer_irq rises: mirrored into mip only when the timer path is built
        mie       = 64'h80;
        timer_irq = 1'b1;
        #1;
`ifdef YSYX_22050550_TIMER_IRQ_EN
        checkOutput("mirror_csren", {56'd0, wbcsren}, 64'h20);
        checkOutput("mirror_wbmip", wbmip, 64'h80);
`else
        checkOutput("mirror_csren", {56'd0, wbcsren}, 64'h00);
        checkOutput("mirror_wbmip", wbmip, 64'h00);
`endif
        tick();
        mip = 64'h80;
        #1;
        checkOutput("mirror_done_csren", {56'd0, wbcsren}, 64'h00);

        // normal commit with interrupt pending
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8000_0020, 64'h8000_0024);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
`ifdef YSYX_22050550_TIMER_IRQ_EN
        checkOutput("irq_csren", {56'd0, wbcsren}, 64'h0B);
        checkOutput("irq_mepc", wbmepc, 64'h8000_0024);
        checkOutput("irq_mcause", wbmcause, 64'h8000_0000_0000_0007);
        tick();
        drainRedirect("irq", 64'h8000_0100);
`else
        checkOutput("irq_ignored_busy", {63'd0, busy}, 64'd0);
        checkOutput("irq_ignored_csren", {56'd0, wbcsren}, 64'd0);
`endif

        // interrupt and ecall on the same commit
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h8000_0080, 64'h8000_0084);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("irqec_mepc", wbmepc, 64'h8000_0080);
`ifdef YSYX_22050550_TIMER_IRQ_EN
        checkOutput("irqec_mcause", wbmcause, 64'h8000_0000_0000_0007);
`else
        checkOutput("irqec_mcause", wbmcause, 64'd11);
`endif
        tick();
        drainRedirect("irqec", 64'h8000_0100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
